osch_tick_gen: RTL

- Sits directly downstream of the internal-oscillator wrapper and is clocked by its raw output (nominal 7 MHz).
- Divides that clock into a one-cycle tick strobe, a 50%-duty square wave and an 8-bit tick counter for LED/heartbeat and timebase use.
- The divisor can be changed at run time through a load/acknowledge handshake. A new divisor takes effect only at a period boundary, so the output never shows a runt period.

---
 rtl/osch_tick_gen.sv | 56 +++++
 1 files changed

// File: rtl/osch_tick_gen.sv
// osch_tick_gen: divides the oscillator clock into tick, square wave and tick count with glitch-free divisor reload
module osch_tick_gen #(
  parameter int DIV_W = 24,
  parameter int DEFAULT_DIV = 7000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_ack,
  output logic             div_err,
  output logic             div_pending,
  output logic             tick,
  output logic             sq_out,
  output logic [7:0]       tick_count
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  logic [DIV_W-1:0] cnt, cur_div, pend_div, nxt_div;
  logic term, load_ok, apply;
  assign term = cnt == '0;
  assign load_ok = div_load && div_value != '0;
  // a pending divisor is taken at a period boundary, or immediately while counting is paused
  assign apply = div_pending && (term || !enable);
  assign nxt_div = div_pending ? pend_div : cur_div;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= DIV_W'(DEFAULT_DIV - 1);
      cur_div <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      div_pending <= 1'b0;
      tick <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
      sq_out <= 1'b0;
      tick_count <= 8'd0;
    end else begin
      tick <= enable && term;
      div_err <= div_load && div_value == '0;
      div_ack <= apply;
      if (enable && term) begin
        cnt <= nxt_div - ONE;
        cur_div <= nxt_div;
        sq_out <= ~sq_out;
        tick_count <= tick_count + 8'd1;
      end else if (enable) begin
        cnt <= cnt - ONE;
      end else if (div_pending) begin
        cnt <= pend_div - ONE;
        cur_div <= pend_div;
      end
      div_pending <= load_ok || (div_pending && !apply);
      if (load_ok) pend_div <= div_value;
    end
  end
endmodule
